// File: rtl/vga_clkgen_prog.sv
// Programs a DCM_CLKGEN M/D pair over its serial PROGCLK/PROGEN/PROGDATA port.
// Optional WAIT-state timeout is enabled by defining VGA_CLKGEN_PROG_TIMEOUT_EN.
module vga_clkgen_prog #(
    parameter int TIMEOUT = 65535
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [7:0] m_val,
    input  logic [7:0] d_val,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       progclk,
    output logic       progdata,
    output logic       progen,
    input  logic       progdone,
    output logic [2:0] dbg_state
);

    // Handshake: start is sampled only while idle (busy low); busy is high from
    // the cycle after acceptance until the cycle done pulses, and error is only
    // meaningful while done is high.

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_LOADD, S_GAP1, S_LOADM, S_GAP2, S_GO, S_WAIT
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] m_q, d_q;
    logic       pd_s1, pd_s2, pd_s3;
    logic       step, pd_rise, capture;
    logic       done_n, error_n, progen_n, progdata_n;
    logic [2:0] bit_idx;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

`ifdef VGA_CLKGEN_PROG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt, tcnt_n;
`endif

    // progclk is high in the cycle before a step, so the DCM sees its rising
    // edge half a period after progen/progdata settled.
    assign step      = progclk;
    assign pd_rise   = pd_s2 & ~pd_s3;
    assign dbg_state = state;
    assign bit_idx   = 3'(cnt_n - 4'd2);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        error_n = 1'b0;
        capture = 1'b0;
`ifdef VGA_CLKGEN_PROG_TIMEOUT_EN
        tcnt_n  = (state == S_WAIT) ? tcnt + 1'b1 : '0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ARM;
                    capture = 1'b1;
                end
            end
            S_ARM: begin
                if (m_q == 8'd0) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    error_n = 1'b1;
                end else if (step) begin
                    state_n = S_LOADD;
                    cnt_n   = 4'd0;
                end
            end
            S_LOADD: begin
                if (step) begin
                    if (cnt == 4'd9) begin
                        state_n = S_GAP1;
                        cnt_n   = 4'd0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            S_GAP1: begin
                if (step) begin
                    if (cnt == 4'd1) begin
                        state_n = S_LOADM;
                        cnt_n   = 4'd0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            S_LOADM: begin
                if (step) begin
                    if (cnt == 4'd9) begin
                        state_n = S_GAP2;
                        cnt_n   = 4'd0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            S_GAP2: begin
                if (step) begin
                    if (cnt == 4'd1) begin
                        state_n = S_GO;
                        cnt_n   = 4'd0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            S_GO: begin
                if (step) begin
                    state_n = S_WAIT;
                    cnt_n   = 4'd0;
                end
            end
            S_WAIT: begin
                if (pd_rise) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
`ifdef VGA_CLKGEN_PROG_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    error_n = 1'b1;
                end
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Serial outputs are decoded from the next state so they are registered and
    // only move on the same edges as the state/counter, i.e. on steps.
    always_comb begin
        progen_n   = 1'b0;
        progdata_n = 1'b0;
        case (state_n)
            S_LOADD: begin
                progen_n   = 1'b1;
                progdata_n = (cnt_n == 4'd0) ? 1'b1 :
                             (cnt_n == 4'd1) ? 1'b0 : d_q[bit_idx];
            end
            S_LOADM: begin
                progen_n   = 1'b1;
                progdata_n = (cnt_n < 4'd2) ? 1'b1 : m_q[bit_idx];
            end
            S_GO:    progen_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            m_q      <= 8'd0;
            d_q      <= 8'd0;
            pd_s1    <= 1'b0;
            pd_s2    <= 1'b0;
            pd_s3    <= 1'b0;
            progclk  <= 1'b0;
            progen   <= 1'b0;
            progdata <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef VGA_CLKGEN_PROG_TIMEOUT_EN
            tcnt     <= '0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pd_s1    <= progdone;
            pd_s2    <= pd_s1;
            pd_s3    <= pd_s2;
            progclk  <= ~progclk;
            progen   <= progen_n;
            progdata <= progdata_n;
            busy     <= (state_n != S_IDLE);
            done     <= done_n;
            error    <= error_n;
`ifdef VGA_CLKGEN_PROG_TIMEOUT_EN
            tcnt     <= tcnt_n;
`endif
            if (capture) begin
                m_q <= m_val;
                d_q <= d_val;
            end
        end
    end

endmodule

// File: tb/tb_vga_clkgen_prog.sv
// Bench for vga_clkgen_prog: expected serial symbols and done/error results are
// queued at stimulus time and popped by independent monitors.
module tb_vga_clkgen_prog;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] m_val = 8'd0;
    logic [7:0] d_val = 8'd0;
    logic       progdone = 1'b0;
    logic       busy, done, error, progclk, progdata, progen;
    logic [2:0] dbg_state;

    vga_clkgen_prog #(.TIMEOUT(100)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .m_val     (m_val),
        .d_val     (d_val),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .progclk   (progclk),
        .progdata  (progdata),
        .progen    (progen),
        .progdone  (progdone),
        .dbg_state (dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    int         total = 0;
    int         bad = 0;
    logic [1:0] exp_q[$];
    logic       exp_err_q[$];
    int         sym_pop = 0;
    bit         in_frame = 1'b0;
    logic [1:0] mon_e;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Symbol monitor: one {progen,progdata} sample per DCM rising edge.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            in_frame = 1'b0;
        end else if (progclk && (in_frame || progen)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL progen_unexpected: got progen=%0d required no activity", progen);
                in_frame = 1'b0;
            end else begin
                mon_e = exp_q.pop_front();
                check("prog_sym", {progen, progdata}, mon_e);
                sym_pop++;
                in_frame = (exp_q.size() != 0);
            end
        end
    end

    // Completion monitor.
    always @(negedge sys_clk) begin
        if (sys_rst_n && done) begin
            if (exp_err_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got done=1 required 0");
            end else begin
                check("done_error", error, exp_err_q.pop_front());
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_seq(input logic [7:0] m, input logic [7:0] d);
        for (int k = 0; k < 10; k++)
            exp_q.push_back({1'b1, (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : d[k-2]});
        repeat (2) exp_q.push_back(2'b00);
        for (int k = 0; k < 10; k++)
            exp_q.push_back({1'b1, (k < 2) ? 1'b1 : m[k-2]});
        repeat (2) exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    task automatic do_start(input logic [7:0] m, input logic [7:0] d, input logic e);
        start = 1'b1;
        m_val = m;
        d_val = d;
        tick();
        start = 1'b0;
        check("busy_rise", busy, 1);
        if (m != 8'd0) push_seq(m, d);
        exp_err_q.push_back(e);
    endtask

    task automatic wait_go_end();
        int n = 0;
        while ((exp_q.size() != 0 || progen) && n < 200) begin
            tick();
            n++;
        end
        check("go_end_in_time", int'(n < 200), 1);
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            tick();
            n++;
            if (done) break;
        end
    endtask

    task automatic wait_syms(input int target);
        int n = 0;
        while (sym_pop < target && n < 300) begin
            tick();
            n++;
        end
        check("syms_reached", int'(n < 300), 1);
    endtask

    task automatic full_run(input logic [7:0] m, input logic [7:0] d);
        int n;
        do_start(m, d, 1'b0);
        wait_go_end();
        repeat (20) tick();
        check("busy_in_wait", busy, 1);
        progdone = 1'b1;
        wait_done(50, n);
        check("done_latency", n, 3);
        tick();
        progdone = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        int  n;
        int  base;
        bit  seen;
        logic p0;

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_progen", progen, 0);
        check("rst_progdata", progdata, 0);
        check("rst_progclk", progclk, 0);
        repeat (3) tick();
        sys_rst_n = 1'b1;

        tick();
        p0 = progclk;
        tick();
        check("progclk_toggle1", progclk, int'(!p0));
        tick();
        check("progclk_toggle2", progclk, int'(p0));

        // Basic programming: M-1=4, D-1=2
        full_run(8'd4, 8'd2);

        // M=1 rejected without touching progen
        do_start(8'd0, 8'd5, 1'b1);
        wait_done(5, n);
        check("m0_done_within2", int'(n <= 2), 1);
        tick();
        check("m0_busy_after", busy, 0);
        repeat (10) tick();

        // Second start during LOADM is ignored
        base = sym_pop;
        do_start(8'hA5, 8'h3C, 1'b0);
        wait_syms(base + 14);
        start = 1'b1;
        m_val = 8'h11;
        d_val = 8'h22;
        tick();
        start = 1'b0;
        wait_go_end();
        repeat (20) tick();
        progdone = 1'b1;
        wait_done(50, n);
        check("done_latency_ignored", n, 3);
        tick();
        progdone = 1'b0;
        repeat (60) tick();

        // progdone already high on entering WAIT must not complete
        do_start(8'h7F, 8'h00, 1'b0);
        progdone = 1'b1;
        wait_go_end();
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("stale_progdone", int'(seen), 0);
        progdone = 1'b0;
        repeat (4) tick();
        progdone = 1'b1;
        wait_done(50, n);
        check("done_latency_fresh", n, 3);
        tick();
        progdone = 1'b0;
        repeat (6) tick();

        // Reset during LOADM data bit 3
        base = sym_pop;
        do_start(8'd4, 8'd2, 1'b0);
        wait_syms(base + 17);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_progen", progen, 0);
        check("midrst_progdata", progdata, 0);
        check("midrst_busy", busy, 0);
        exp_q.delete();
        exp_err_q.delete();
        repeat (2) tick();
        sys_rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (progen || busy) seen = 1'b1;
        end
        check("midrst_quiet", int'(seen), 0);
        full_run(8'h3B, 8'h81);

`ifdef VGA_CLKGEN_PROG_TIMEOUT_EN
        do_start(8'h10, 8'h20, 1'b1);
        wait_go_end();
        wait_done(200, n);
        check("timeout_latency", n, 100);
        repeat (6) tick();
`endif

        repeat (10) tick();
        check("sym_queue_empty", exp_q.size(), 0);
        check("done_queue_empty", exp_err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
